// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_driver                                                            |
// | Time-multiplexed N-digit 7-segment driver with double-buffered value,      |
// | leading-zero blanking, anti-ghost blank interval and selectable polarity.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16,
  parameter bit ACT_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                hex_mode,
  input  logic                lzb,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame
);

  localparam int c_CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(PRESCALE - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_BLANK = c_CNT_W'(BLANK);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [4*DIGITS-1:0] r_shadowVal;
  logic [DIGITS-1:0]   r_shadowDp;
  logic [4*DIGITS-1:0] r_activeVal;
  logic [DIGITS-1:0]   r_activeDp;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_digSel;
  logic                r_frame;

  logic                w_slotEnd;
  logic                w_wrap;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_zeroFrom;
  logic                w_lzBlank;
  logic [6:0]          w_segHi;
  logic                w_dpHi;
  logic [DIGITS-1:0]   w_digHi;

  function automatic logic [6:0] decodeNibble(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = hex ? 7'h77 : 7'h00;
      4'hB: s = hex ? 7'h7C : 7'h00;
      4'hC: s = hex ? 7'h39 : 7'h00;
      4'hD: s = hex ? 7'h5E : 7'h00;
      4'hE: s = hex ? 7'h79 : 7'h00;
      default: s = hex ? 7'h71 : 7'h00;
    endcase
    return s;
  endfunction

  // Bit k set when digit k and every more significant digit hold zero
  for (genvar k = 0; k < DIGITS; k++) begin : g_zeroFrom
    assign w_zeroFrom[k] = ~|r_activeVal[4*DIGITS-1:4*k];
  end

  always_comb begin
    w_slotEnd = en && (r_cnt == c_CNT_LAST);
    w_wrap    = w_slotEnd && (r_idx == c_IDX_LAST);
    w_nib     = r_activeVal[4*r_idx +: 4];
    w_lzBlank = lzb && (r_idx != '0) && w_zeroFrom[r_idx];
    w_segHi   = w_lzBlank ? 7'h00 : decodeNibble(w_nib, hex_mode);
    w_dpHi    = r_activeDp[r_idx];
    w_digHi   = (r_cnt < c_CNT_BLANK) ? '0 : (DIGITS'(1) << r_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shadowVal <= '0;
      r_shadowDp  <= '0;
      r_activeVal <= '0;
      r_activeDp  <= '0;
      r_seg       <= {7{ACT_LOW}};
      r_dp        <= ACT_LOW;
      r_digSel    <= {DIGITS{ACT_LOW}};
      r_frame     <= 1'b0;
    end else begin
      if (load) begin
        r_shadowVal <= value;
        r_shadowDp  <= dp_in;
      end
      // A load coinciding with the swap bypasses the shadow so new data is never lost
      if (w_wrap || !en) begin
        r_activeVal <= load ? value : r_shadowVal;
        r_activeDp  <= load ? dp_in : r_shadowDp;
      end

      if (!en) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (w_slotEnd) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      r_frame <= w_wrap;

      if (!en) begin
        r_seg    <= {7{ACT_LOW}};
        r_dp     <= ACT_LOW;
        r_digSel <= {DIGITS{ACT_LOW}};
      end else begin
        r_seg    <= w_segHi ^ {7{ACT_LOW}};
        r_dp     <= w_dpHi ^ ACT_LOW;
        r_digSel <= w_digHi ^ {DIGITS{ACT_LOW}};
      end
    end
  end

  assign seg     = r_seg;
  assign dp      = r_dp;
  assign dig_sel = r_digSel;
  assign frame   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_scan_driver                                                         |
// | Checks active-high and active-low instances against a frame-time model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seg_scan_driver;

  localparam int c_P     = 8;
  localparam int c_BL    = 2;
  localparam int c_ND    = 4;
  localparam int c_FRAME = c_P * c_ND;
  localparam logic [6:0] c_SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        lzb;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] dig0, dig1;
  logic       frame0, frame1;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.DIGITS(c_ND), .PRESCALE(c_P), .BLANK(c_BL), .ACT_LOW(1'b0)) u_dutHi (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .lzb(lzb), .seg(seg0), .dp(dp0), .dig_sel(dig0), .frame(frame0)
  );

  seg_scan_driver #(.DIGITS(c_ND), .PRESCALE(c_P), .BLANK(c_BL), .ACT_LOW(1'b1)) u_dutLo (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .lzb(lzb), .seg(seg1), .dp(dp1), .dig_sel(dig1), .frame(frame1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one time counter inside the frame; digit = t / PRESCALE, position = t % PRESCALE
  int         mT;
  logic [15:0] mShadow, mAct;
  logic [3:0]  mShadowDp, mActDp;
  logic [6:0]  expSeg;
  logic        expDp;
  logic [3:0]  expDig;
  logic        expFrame;

  function automatic logic [6:0] modelSeg(input logic [15:0] act, input int d,
                                          input logic hex, input logic lz);
    logic [3:0] nib;
    nib = act[4*d +: 4];
    if (lz && d > 0 && (act >> (4*d)) == 16'h0) return 7'h00;
    if (nib >= 4'd10 && !hex) return 7'h00;
    return c_SEGTAB[nib];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mT        <= 0;
      mShadow   <= '0;
      mShadowDp <= '0;
      mAct      <= '0;
      mActDp    <= '0;
      expSeg    <= '0;
      expDp     <= 1'b0;
      expDig    <= '0;
      expFrame  <= 1'b0;
    end else begin
      mT <= en ? (mT + 1) % c_FRAME : 0;
      if (load) begin
        mShadow   <= value;
        mShadowDp <= dp_in;
      end
      if (!en || mT == c_FRAME - 1) begin
        mAct   <= load ? value : mShadow;
        mActDp <= load ? dp_in : mShadowDp;
      end
      expFrame <= en && (mT == c_FRAME - 1);
      if (!en) begin
        expSeg <= '0;
        expDp  <= 1'b0;
        expDig <= '0;
      end else begin
        expSeg <= modelSeg(mAct, mT / c_P, hex_mode, lzb);
        expDp  <= mActDp[mT / c_P];
        expDig <= ((mT % c_P) < c_BL) ? 4'b0000 : 4'(1 << (mT / c_P));
      end
    end
  end

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("hi.seg",   {1'b0, seg0}, {1'b0, expSeg});
    cmp("hi.dp",    {7'b0, dp0},  {7'b0, expDp});
    cmp("hi.dig",   {4'b0, dig0}, {4'b0, expDig});
    cmp("hi.frame", {7'b0, frame0}, {7'b0, expFrame});
    cmp("lo.seg",   {1'b0, seg1}, {1'b0, ~expSeg});
    cmp("lo.dp",    {7'b0, dp1},  {7'b0, ~expDp});
    cmp("lo.dig",   {4'b0, dig1}, {4'b0, ~expDig});
    cmp("lo.frame", {7'b0, frame1}, {7'b0, expFrame});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge just after the first enabled cycle (slot 0, cnt 0)
  task automatic restart(input logic [15:0] v, input logic [3:0] d);
    en = 1'b0; load = 1'b1; value = v; dp_in = d;
    step(1);
    load = 1'b0; en = 1'b1;
    step(1);
  endtask

  task automatic checkFrame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] e [4];
    e = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("%s.d%0d", nm, k), {1'b0, seg0}, {1'b0, e[k]});
      step(c_P);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; hex_mode = 1'b0; lzb = 1'b0;
    step(1);
    cmp("rst.seg0", {1'b0, seg0}, 8'h00);
    cmp("rst.dig0", {4'b0, dig0}, 8'h00);
    cmp("rst.seg1", {1'b0, seg1}, 8'h7F);
    cmp("rst.dig1", {4'b0, dig1}, 8'h0F);
    cmp("rst.dp1",  {7'b0, dp1},  8'h01);
    #2 rst_n = 1'b1;
    step(1);

    restart(16'h1234, 4'b0000);
    cmp("s0.blank.dig", {4'b0, dig0}, 8'h00);
    cmp("s0.blank.seg", {1'b0, seg0}, 8'h66);
    step(2);
    cmp("s0.dig", {4'b0, dig0}, 8'h01);
    cmp("s0.seg", {1'b0, seg0}, 8'h66);
    step(8);
    cmp("s1.dig", {4'b0, dig0}, 8'h02);
    cmp("s1.seg", {1'b0, seg0}, 8'h4F);
    step(8);
    cmp("s2.dig", {4'b0, dig0}, 8'h04);
    cmp("s2.seg", {1'b0, seg0}, 8'h5B);
    step(8);
    cmp("s3.dig", {4'b0, dig0}, 8'h08);
    cmp("s3.seg", {1'b0, seg0}, 8'h06);
    step(5);
    cmp("frame.hi", {7'b0, frame0}, 8'h01);
    step(1);
    cmp("frame.lo", {7'b0, frame0}, 8'h00);

    lzb = 1'b1;
    restart(16'h0050, 4'b0000);
    checkFrame("lzb50", 7'h3F, 7'h6D, 7'h00, 7'h00);
    restart(16'h0000, 4'b0000);
    checkFrame("lzb0", 7'h3F, 7'h00, 7'h00, 7'h00);
    lzb = 1'b0;

    hex_mode = 1'b1;
    restart(16'hABEF, 4'b0000);
    checkFrame("hex1", 7'h71, 7'h79, 7'h7C, 7'h77);
    hex_mode = 1'b0;
    restart(16'hABEF, 4'b0000);
    checkFrame("hex0", 7'h00, 7'h00, 7'h00, 7'h00);

    restart(16'h1234, 4'b0000);
    value = 16'h1111; load = 1'b1;
    step(1);
    load = 1'b0;
    step(7);
    cmp("midload.s1", {1'b0, seg0}, 8'h4F);
    step(22);
    value = 16'h5678; load = 1'b1;
    step(1);
    load = 1'b0;
    cmp("bndload.frame", {7'b0, frame0}, 8'h01);
    cmp("bndload.old3",  {1'b0, seg0},   8'h06);
    step(1);
    cmp("bndload.new0",  {1'b0, seg0},   8'h7F);

    restart(16'h8888, 4'b0100);
    step(18);
    cmp("lo.dp2",  {7'b0, dp1},  8'h00);
    cmp("lo.dig2", {4'b0, dig1}, 8'h0B);
    en = 1'b0;
    step(1);
    cmp("lo.idle.seg", {1'b0, seg1}, 8'h7F);
    cmp("lo.idle.dp",  {7'b0, dp1},  8'h01);
    cmp("lo.idle.dig", {4'b0, dig1}, 8'h0F);

    restart(16'h1234, 4'b0000);
    step(10);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst.dig0", {4'b0, dig0}, 8'h00);
    cmp("arst.seg1", {1'b0, seg1}, 8'h7F);
    #1 rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 149) != 0);
      load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: value = 16'($urandom);
        1: value = 16'($urandom) >> (4 * $urandom_range(1, 4));
        default: value = 16'($urandom) & 16'h9999;
      endcase
      dp_in = 4'($urandom);
      if ($urandom_range(0, 63) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 63) == 0) lzb = ~lzb;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
